// File: rtl/axi_io_pmp_pkg.sv
// Shared types and constants for the IO-PMP denied-request path: AXI channel
// structs, FSM state encodings and the default error response values.
package axi_io_pmp_pkg;

    localparam int unsigned AXI_ID_W   = 8;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_USER_W = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Shared with the IO-PMP top so both sides agree on what a denial looks like.
    localparam logic [1:0]            ERR_RESP_DEFAULT = RESP_SLVERR;
    localparam logic [AXI_DATA_W-1:0] ERR_DATA_DEFAULT = '1;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DRAIN,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [AXI_USER_W-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
        logic [AXI_USER_W-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [AXI_USER_W-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_io_pmp_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } axi_io_pmp_rsp_t;

endpackage

// File: rtl/axi_io_pmp_sat_cnt.sv
// Saturating up-counter with synchronous reset; holds at all-ones.
module axi_io_pmp_sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/axi_io_pmp_err_slv.sv
// Terminating AXI4 responder for IO-PMP denied traffic: drains writes, answers
// reads with error data, and keeps saturating per-direction denial counters.
module axi_io_pmp_err_slv
    import axi_io_pmp_pkg::*;
#(
    parameter int unsigned           ID_WIDTH   = 8,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           CNT_WIDTH  = 16,
    parameter logic [1:0]            ERR_RESP   = ERR_RESP_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = ERR_DATA_DEFAULT,
    parameter type                   axi_req_t  = axi_io_pmp_pkg::axi_io_pmp_req_t,
    parameter type                   axi_rsp_t  = axi_io_pmp_pkg::axi_io_pmp_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  axi_req_t             slv_req_i,
    output axi_rsp_t             slv_resp_o,
    output logic [CNT_WIDTH-1:0] wr_err_cnt_o,
    output logic [CNT_WIDTH-1:0] rd_err_cnt_o,
    output logic                 busy_o
);

    wr_state_e           wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;
    logic                wr_done;

    rd_state_e           rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0] ar_id_q, ar_id_d;
    logic [7:0]          ar_len_q, ar_len_d;
    logic [7:0]          beat_q, beat_d;
    logic                rd_done;
    logic                r_last;

    // Compared before increment, so a 256-beat burst ends on beat 255 without wrapping.
    assign r_last = (beat_q == ar_len_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            aw_id_q    <= '0;
            rd_state_q <= R_IDLE;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            beat_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_id_q    <= aw_id_d;
            rd_state_q <= rd_state_d;
            ar_id_q    <= ar_id_d;
            ar_len_q   <= ar_len_d;
            beat_q     <= beat_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_id_d    = aw_id_q;
        wr_done    = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (slv_req_i.aw_valid) begin
                    aw_id_d    = slv_req_i.aw.id;
                    wr_state_d = W_DRAIN;
                end
            end
            W_DRAIN: begin
                if (slv_req_i.w_valid && slv_req_i.w.last) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (slv_req_i.b_ready) begin
                    wr_done    = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ar_id_d    = ar_id_q;
        ar_len_d   = ar_len_q;
        beat_d     = beat_q;
        rd_done    = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (slv_req_i.ar_valid) begin
                    ar_id_d    = slv_req_i.ar.id;
                    ar_len_d   = slv_req_i.ar.len;
                    beat_d     = '0;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (slv_req_i.r_ready) begin
                    beat_d = beat_q + 8'd1;
                    if (r_last) begin
                        rd_done    = 1'b1;
                        rd_state_d = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Outputs decode from state and latched fields only; no input-to-output path.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = (wr_state_q == W_IDLE);
        slv_resp_o.w_ready  = (wr_state_q == W_DRAIN);
        slv_resp_o.b_valid  = (wr_state_q == W_RESP);
        slv_resp_o.b.id     = aw_id_q;
        slv_resp_o.b.resp   = ERR_RESP;
        slv_resp_o.ar_ready = (rd_state_q == R_IDLE);
        slv_resp_o.r_valid  = (rd_state_q == R_DATA);
        slv_resp_o.r.id     = ar_id_q;
        slv_resp_o.r.data   = ERR_DATA;
        slv_resp_o.r.resp   = ERR_RESP;
        slv_resp_o.r.last   = (rd_state_q == R_DATA) && r_last;
    end

    assign busy_o = (wr_state_q != W_IDLE) || (rd_state_q != R_IDLE);

    axi_io_pmp_sat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_wr_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (wr_done),
        .cnt_o (wr_err_cnt_o)
    );

    axi_io_pmp_sat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_rd_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (rd_done),
        .cnt_o (rd_err_cnt_o)
    );

endmodule

// File: tb/tb_axi_io_pmp_err_slv.sv
// Scoreboard bench for axi_io_pmp_err_slv: randomized write/read drivers push
// expected responses, a negedge monitor pops and compares on every handshake.
module tb_axi_io_pmp_err_slv;
    import axi_io_pmp_pkg::*;

    localparam int unsigned CNT_W   = 3;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          BUDGET  = 2000;
    localparam logic [1:0]  EXP_RESP = 2'b10;
    localparam logic [63:0] EXP_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [7:0] id;
        logic       last;
    } r_exp_t;

    logic            clk;
    logic            rst;
    axi_io_pmp_req_t req, req_w, req_r;
    axi_io_pmp_rsp_t rsp;
    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;
    logic mon_en = 1'b0;

    logic [7:0] exp_b_q[$];
    r_exp_t     exp_r_q[$];
    int         exp_wr = 0;
    int         exp_rd = 0;

    always_comb begin
        req          = req_w;
        req.ar       = req_r.ar;
        req.ar_valid = req_r.ar_valid;
        req.r_ready  = req_r.r_ready;
    end

    axi_io_pmp_err_slv #(
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .slv_req_i    (req),
        .slv_resp_o   (rsp),
        .wr_err_cnt_o (wr_cnt),
        .rd_err_cnt_o (rd_cnt),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Scoreboard monitor: counters first (reflecting handshakes seen on earlier
    // negedges), then stability of stalled payloads, then pops on handshakes.
    logic       b_stall = 1'b0, r_stall = 1'b0;
    logic [9:0] b_prev;
    logic [10:0] r_prev_meta;
    logic [63:0] r_prev_data;

    always @(negedge clk) begin
        if (!mon_en) begin
            exp_b_q.delete();
            exp_r_q.delete();
            exp_wr  = 0;
            exp_rd  = 0;
            b_stall = 1'b0;
            r_stall = 1'b0;
        end else begin
            check("wr_err_cnt", 64'(wr_cnt), 64'(exp_wr));
            check("rd_err_cnt", 64'(rd_cnt), 64'(exp_rd));
            if (b_stall) begin
                check("b_stall_valid", 64'(rsp.b_valid), 64'd1);
                check("b_stall_payload", 64'({rsp.b.id, rsp.b.resp}), 64'(b_prev));
            end
            if (r_stall) begin
                check("r_stall_valid", 64'(rsp.r_valid), 64'd1);
                check("r_stall_meta", 64'({rsp.r.id, rsp.r.resp, rsp.r.last}), 64'(r_prev_meta));
                check("r_stall_data", rsp.r.data, r_prev_data);
            end
            if (rsp.b_valid && req.b_ready) begin
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [7:0] e;
                    e = exp_b_q.pop_front();
                    check("b_id", 64'(rsp.b.id), 64'(e));
                    check("b_resp", 64'(rsp.b.resp), 64'(EXP_RESP));
                    check("b_user", 64'(rsp.b.user), 64'd0);
                    exp_wr = sat_inc(exp_wr);
                end
            end
            if (rsp.r_valid && req.r_ready) begin
                if (exp_r_q.size() == 0) begin
                    check("r_unexpected", 64'd1, 64'd0);
                end else begin
                    r_exp_t e;
                    e = exp_r_q.pop_front();
                    check("r_id", 64'(rsp.r.id), 64'(e.id));
                    check("r_last", 64'(rsp.r.last), 64'(e.last));
                    check("r_data", rsp.r.data, EXP_DATA);
                    check("r_resp", 64'(rsp.r.resp), 64'(EXP_RESP));
                    check("r_user", 64'(rsp.r.user), 64'd0);
                    if (e.last) exp_rd = sat_inc(exp_rd);
                end
            end
            b_stall     = rsp.b_valid && !req.b_ready;
            b_prev      = {rsp.b.id, rsp.b.resp};
            r_stall     = rsp.r_valid && !req.r_ready;
            r_prev_meta = {rsp.r.id, rsp.r.resp, rsp.r.last};
            r_prev_data = rsp.r.data;
        end
    end

    // pre > 0 holds a single last W beat valid for that many cycles before AW (use len=0).
    task automatic do_write(input logic [7:0] id, input logic [7:0] len, input int pre);
        int beats;
        int guard;
        logic hs;
        @(posedge clk); #1;
        if (pre > 0) begin
            req_w.w_valid = 1'b1;
            req_w.w.last  = 1'b1;
            repeat (pre) begin
                @(negedge clk);
                check("w_ready_before_aw", 64'(rsp.w_ready), 64'd0);
                @(posedge clk); #1;
            end
        end
        req_w.aw_valid = 1'b1;
        req_w.aw.id    = id;
        req_w.aw.len   = len;
        req_w.aw.addr  = $urandom;
        exp_b_q.push_back(id);
        guard = 0;
        forever begin
            @(negedge clk);
            if (rsp.aw_ready) break;
            guard++;
            if (guard > BUDGET) begin
                check("aw_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_w.aw_valid = 1'b0;
        beats = 0;
        guard = 0;
        while (beats <= int'(len) && guard < BUDGET) begin
            req_w.w_valid = (pre > 0 && beats == 0) ? 1'b1 : ($urandom_range(3) != 0);
            req_w.w.last  = (beats == int'(len));
            req_w.w.data  = {$urandom, $urandom};
            @(negedge clk);
            check("w_ready_drain", 64'(rsp.w_ready), 64'd1);
            if (req_w.w_valid) beats++;
            guard++;
            @(posedge clk); #1;
        end
        if (guard >= BUDGET) check("w_timeout", 64'd0, 64'd1);
        req_w.w_valid = 1'b0;
        req_w.w.last  = 1'b0;
        guard = 0;
        do begin
            req_w.b_ready = $urandom_range(1);
            @(negedge clk);
            check("b_valid_wait", 64'(rsp.b_valid), 64'd1);
            hs = req_w.b_ready;
            guard++;
            @(posedge clk); #1;
        end while (!hs && guard < BUDGET);
        if (!hs) check("b_timeout", 64'd0, 64'd1);
        req_w.b_ready = 1'b0;
        @(negedge clk);
        check("aw_ready_after_b", 64'(rsp.aw_ready), 64'd1);
        check("b_valid_after_b", 64'(rsp.b_valid), 64'd0);
    endtask

    // mode: 0 r_ready held high, 1 toggling every other cycle, 2 random.
    task automatic do_read(input logic [7:0] id, input logic [7:0] len, input int mode);
        int beats;
        int cyc;
        int guard;
        r_exp_t e;
        @(posedge clk); #1;
        req_r.ar_valid = 1'b1;
        req_r.ar.id    = id;
        req_r.ar.len   = len;
        req_r.ar.addr  = $urandom;
        for (int b = 0; b <= int'(len); b++) begin
            e.id   = id;
            e.last = (b == int'(len));
            exp_r_q.push_back(e);
        end
        guard = 0;
        forever begin
            @(negedge clk);
            if (rsp.ar_ready) break;
            guard++;
            if (guard > BUDGET) begin
                check("ar_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_r.ar_valid = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats <= int'(len) && cyc < BUDGET) begin
            case (mode)
                0:       req_r.r_ready = 1'b1;
                1:       req_r.r_ready = (cyc % 2 == 0);
                default: req_r.r_ready = $urandom_range(1);
            endcase
            @(negedge clk);
            check("r_valid_wait", 64'(rsp.r_valid), 64'd1);
            if (req_r.r_ready) beats++;
            cyc++;
            @(posedge clk); #1;
        end
        if (cyc >= BUDGET) check("r_timeout", 64'd0, 64'd1);
        if (mode == 0) check("r_burst_cycles", 64'(cyc), 64'(int'(len) + 1));
        req_r.r_ready = 1'b0;
        @(negedge clk);
        check("ar_ready_after_r", 64'(rsp.ar_ready), 64'd1);
        check("r_valid_after_last", 64'(rsp.r_valid), 64'd0);
    endtask

    initial begin
        req_w = '0;
        req_r = '0;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready", 64'(rsp.aw_ready), 64'd1);
        check("rst_ar_ready", 64'(rsp.ar_ready), 64'd1);
        check("rst_w_ready", 64'(rsp.w_ready), 64'd0);
        check("rst_b_valid", 64'(rsp.b_valid), 64'd0);
        check("rst_r_valid", 64'(rsp.r_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_cnt", 64'(wr_cnt), 64'd0);
        check("rst_rd_cnt", 64'(rd_cnt), 64'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        do_write(8'h5A, 8'd3, 0);
        check("wr_cnt_first", 64'(wr_cnt), 64'd1);
        do_read(8'h11, 8'd7, 0);
        check("rd_cnt_first", 64'(rd_cnt), 64'd1);

        fork
            do_read(8'h33, 8'd255, 1);
            begin
                repeat (5) @(posedge clk);
                do_write(8'hC3, 8'd2, 0);
                @(negedge clk);
                check("busy_during_read", 64'(busy), 64'd1);
            end
        join
        @(negedge clk);
        check("busy_after_both", 64'(busy), 64'd0);

        do_write(8'h77, 8'd0, 5);

        for (int i = 0; i < 12; i++) begin
            automatic logic [7:0] wid  = 8'($urandom);
            automatic logic [7:0] wlen = 8'($urandom_range(7));
            automatic logic [7:0] rid  = 8'($urandom);
            automatic logic [7:0] rlen = 8'($urandom_range(15));
            fork
                do_write(wid, wlen, 0);
                do_read(rid, rlen, 2);
            join
        end
        @(negedge clk);
        check("wr_cnt_saturated", 64'(wr_cnt), 64'(CNT_MAX));
        check("rd_cnt_saturated", 64'(rd_cnt), 64'(CNT_MAX));

        // Reset in the middle of a read burst: no response, counters cleared.
        @(posedge clk); #1;
        req_r.ar_valid = 1'b1;
        req_r.ar.id    = 8'h42;
        req_r.ar.len   = 8'd20;
        begin
            r_exp_t e;
            for (int b = 0; b <= 20; b++) begin
                e.id   = 8'h42;
                e.last = (b == 20);
                exp_r_q.push_back(e);
            end
        end
        @(negedge clk);
        check("abort_ar_ready", 64'(rsp.ar_ready), 64'd1);
        @(posedge clk); #1;
        req_r.ar_valid = 1'b0;
        req_r.r_ready  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        req_r.r_ready = 1'b0;
        rst    = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_r_valid", 64'(rsp.r_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ar_ready_rst", 64'(rsp.ar_ready), 64'd1);
        check("abort_rd_cnt", 64'(rd_cnt), 64'd0);
        check("abort_wr_cnt", 64'(wr_cnt), 64'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        do_read(8'h42, 8'd3, 0);
        check("rd_cnt_after_abort", 64'(rd_cnt), 64'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
